// File: rtl/mux2to1_pkg.sv
// Shared defaults for the mux2to1 block.
package mux2to1_pkg;
  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/mux2to1_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mux2to1_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !sat) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/mux2to1.sv
// 2:1 mux with a registered copy of the result and a sel-transition counter.
module mux2to1
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] switch_cnt,
  output logic             cnt_sat
);
  // Ternary keeps bits where a==b when sel is X, without inferring storage.
  assign y = sel ? b : a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel;
      if (en) y_q <= y;
    end
  end

  mux2to1_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sel != sel_q),
    .clr   (clr_cnt),
    .cnt   (switch_cnt),
    .sat   (cnt_sat)
  );
endmodule

// File: tb/tb_mux2to1.sv
// Bench for mux2to1: default, CNT_W=2 and WIDTH=8 instances share control inputs.
module tb_mux2to1;
  logic clk = 1'b0, run = 1'b0;
  logic rst_n, sel, en, clr_cnt, a, b;
  logic [7:0] a8, b8;

  logic y, y_q, sel_q, sat;
  logic [15:0] cnt;
  logic ys, yqs, selqs, sats;
  logic [1:0] cnts;
  logic [7:0] y8, yq8;
  logic selq8, sat8;
  logic [15:0] cnt8;

  always #5 if (run) clk = ~clk;

  mux2to1 dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .en(en),
    .clr_cnt(clr_cnt), .y(y), .y_q(y_q), .sel_q(sel_q), .switch_cnt(cnt), .cnt_sat(sat));
  mux2to1 #(.WIDTH(1), .CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
    .en(en), .clr_cnt(clr_cnt), .y(ys), .y_q(yqs), .sel_q(selqs), .switch_cnt(cnts),
    .cnt_sat(sats));
  mux2to1 #(.WIDTH(8)) dut_w (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel), .en(en),
    .clr_cnt(clr_cnt), .y(y8), .y_q(yq8), .sel_q(selq8), .switch_cnt(cnt8), .cnt_sat(sat8));

  typedef struct {
    string      name;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic       sel, a, b;
    logic [7:0] a8, b8;
    logic       ey;
    logic [7:0] ey8;
  } vec_t;
  vec_t vecs[8];

  task automatic expect_v(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard-empty: got %h with no expectation queued", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      sel = ~sel;
      step();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'h34};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h5A, 8'hC3, 1'b0, 8'h5A};
    vecs[6] = '{1'bx, 1'b1, 1'b1, 8'hF0, 8'hF3, 1'b1, 8'b1111_00xx};
    vecs[7] = '{1'bx, 1'b0, 1'b1, 8'h00, 8'h00, 1'bx, 8'h00};

    // Clock idle, en/clr_cnt/rst_n left undriven: pure combinational mux.
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b;
      a8 = vecs[i].a8; b8 = vecs[i].b8;
      expect_v($sformatf("comb_y[%0d]", i), 32'(vecs[i].ey));
      expect_v($sformatf("comb_y8[%0d]", i), 32'(vecs[i].ey8));
      #10;
      chk(32'(y));
      chk(32'(y8));
    end

    // Reset state
    rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0; sel = 1'b0; a = 1'b0; b = 1'b0;
    #2;
    expect_v("rst_y_q", 0);      chk(32'(y_q));
    expect_v("rst_sel_q", 0);    chk(32'(sel_q));
    expect_v("rst_cnt", 0);      chk(32'(cnt));
    expect_v("rst_sat_s", 0);    chk(32'(sats));
    run = 1'b1;
    step(); step();
    rst_n = 1'b1;

    // Registered path
    en = 1'b1; sel = 1'b1; a = 1'b0; b = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
    step();
    expect_v("yq_load", 1);      chk(32'(y_q));
    expect_v("yq8_load", 8'h3C); chk(32'(yq8));
    expect_v("selq_load", 1);    chk(32'(sel_q));
    expect_v("cnt_first", 1);    chk(32'(cnt));
    en = 1'b0; b = 1'b0;
    step();
    expect_v("yq_hold", 1);      chk(32'(y_q));

    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    expect_v("cnt_clr", 0);      chk(32'(cnt));

    // Five toggles: 16-bit counter reaches 5, 2-bit counter saturates at 3
    toggle(5);
    expect_v("cnt_5", 5);        chk(32'(cnt));
    expect_v("cnt_s_sat", 3);    chk(32'(cnts));
    expect_v("sat_s_hi", 1);     chk(32'(sats));
    expect_v("sat_lo", 0);       chk(32'(sat));

    // Clear beats a simultaneous transition
    clr_cnt = 1'b1; sel = ~sel;
    step();
    clr_cnt = 1'b0;
    expect_v("clr_prio", 0);     chk(32'(cnt));
    expect_v("clr_prio_s", 0);   chk(32'(cnts));
    expect_v("clr_sat_s", 0);    chk(32'(sats));
    expect_v("selq_track", 32'(sel)); chk(32'(sel_q));

    toggle(4);
    expect_v("cnt_4", 4);        chk(32'(cnt));
    expect_v("cnt_s_4tog", 3);   chk(32'(cnts));
    expect_v("sat_s_4tog", 1);   chk(32'(sats));
    toggle(1);
    expect_v("cnt_s_nowrap", 3); chk(32'(cnts));
    expect_v("cnt_5b", 5);       chk(32'(cnt));
    expect_v("yq_hold2", 1);     chk(32'(y_q));

    // Async reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    expect_v("arst_cnt", 0);     chk(32'(cnt));
    expect_v("arst_cnt_s", 0);   chk(32'(cnts));
    expect_v("arst_sat_s", 0);   chk(32'(sats));
    expect_v("arst_y_q", 0);     chk(32'(y_q));
    expect_v("arst_sel_q", 0);   chk(32'(sel_q));
    sel = 1'b0; a = 1'b1; b = 1'b0; a8 = 8'h11; b8 = 8'h22;
    #1;
    expect_v("arst_y_a", 1);     chk(32'(y));
    expect_v("arst_y8_a", 8'h11); chk(32'(y8));
    sel = 1'b1;
    #1;
    expect_v("arst_y_b", 0);     chk(32'(y));
    expect_v("arst_y8_b", 8'h22); chk(32'(y8));

    // After release the count restarts from zero
    step();
    expect_v("rst_held_cnt", 0); chk(32'(cnt));
    rst_n = 1'b1;
    step();
    expect_v("post_rst_cnt", 1); chk(32'(cnt));
    expect_v("post_rst_selq", 1); chk(32'(sel_q));
    en = 1'b1; sel = 1'b0; a = 1'b1;
    step();
    expect_v("yq_sel_a", 1);     chk(32'(y_q));

    if (sbq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard-leftover: %0d expectations never compared", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
